// File: rtl/av_pkg.sv
// -----------------------------------------------------------------------------
// av_pkg
// Shared constants and types for the av_serial_vector serial-to-parallel
// accumulator.
//   AV_WIDTH_DEFAULT : default vector length in bits
//   av_vec_t         : vector type at the default width
// -----------------------------------------------------------------------------
package av_pkg;

    localparam int AV_WIDTH_DEFAULT = 8;

    typedef logic [AV_WIDTH_DEFAULT-1:0] av_vec_t;

endpackage : av_pkg

// File: rtl/av_bit_counter.sv
// -----------------------------------------------------------------------------
// av_bit_counter
// Modulo-WIDTH bit counter. It advances on every rising edge of iClk. oWrap
// is high while the count sits at WIDTH-1, which means the next edge samples
// the last bit of a frame.
// Ports:
//   iClk    in  1  clock
//   iRst_n  in  1  asynchronous active-low reset; clears the count to 0
//   oWrap   out 1  high while count == WIDTH-1
// -----------------------------------------------------------------------------
module av_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic iClk,
    input  logic iRst_n,
    output logic oWrap
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] r_count;

    assign oWrap = (r_count == CW'(WIDTH - 1));

    // An explicit wrap is needed because WIDTH need not be a power of two.
    // NOTE: sequential state uses non-blocking (<=) so that every flop samples
    // its pre-edge inputs, whatever order the blocks are evaluated in.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_count <= '0;
        end else if (oWrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule : av_bit_counter

// File: rtl/av_serial_vector.sv
// -----------------------------------------------------------------------------
// av_serial_vector
// Serial-to-parallel accumulator. It shifts iSignal into a WIDTH-bit register
// on every rising edge. When WIDTH new bits have been collected, it pulses
// oValid for one cycle and captures the completed vector in oWord.
// Parameters:
//   WIDTH      vector length, 2..32
//   MSB_FIRST  1: new bit enters bit 0 and the vector shifts toward the MSB
//              0: new bit enters bit WIDTH-1 and the vector shifts toward the LSB
// Ports:
//   iClk     in  1      clock
//   iRst_n   in  1      asynchronous active-low reset
//   iSignal  in  1      serial data bit
//   oVector  out WIDTH  live shift register contents
//   oValid   out 1      one-cycle frame-complete strobe
//   oWord    out WIDTH  snapshot of the last completed frame
// -----------------------------------------------------------------------------
module av_serial_vector
    import av_pkg::*;
#(
    parameter int WIDTH     = AV_WIDTH_DEFAULT,
    parameter int MSB_FIRST = 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iSignal,
    output logic [WIDTH-1:0] oVector,
    output logic             oValid,
    output logic [WIDTH-1:0] oWord
);

    logic [WIDTH-1:0] r_vec;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic [WIDTH-1:0] w_vec_next;
    logic             w_wrap;

    av_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .oWrap  (w_wrap)
    );

    // NOTE: the default assignment first keeps this block free of latches
    // even if a branch is later edited out.
    always_comb begin
        w_vec_next = r_vec;
        if (MSB_FIRST != 0) begin
            w_vec_next = {r_vec[WIDTH-2:0], iSignal};
        end else begin
            w_vec_next = {iSignal, r_vec[WIDTH-1:1]};
        end
    end

    // oWord loads the same value that oVector shows while oValid is high,
    // so it captures w_vec_next rather than r_vec.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_vec   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_vec   <= w_vec_next;
            r_valid <= w_wrap;
            if (w_wrap) begin
                r_word <= w_vec_next;
            end
        end
    end

    assign oVector = r_vec;
    assign oValid  = r_valid;
    assign oWord   = r_word;

endmodule : av_serial_vector

// File: tb/tb_av_serial_vector.sv
// -----------------------------------------------------------------------------
// tb_av_serial_vector
// Directed bench. Two instances share one clock, reset and serial input:
// dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0). Inputs are driven on the
// falling edge and outputs are checked on the following falling edge.
// -----------------------------------------------------------------------------
module tb_av_serial_vector;
    import av_pkg::*;

    logic    iClk;
    logic    iRst_n;
    logic    iSignal;
    av_vec_t vec_m, word_m, vec_l, word_l;
    logic    valid_m, valid_l;

    int checks = 0;
    int errors = 0;

    av_serial_vector #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iSignal (iSignal),
        .oVector (vec_m),
        .oValid  (valid_m),
        .oWord   (word_m)
    );

    av_serial_vector #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iSignal (iSignal),
        .oVector (vec_l),
        .oValid  (valid_l),
        .oWord   (word_l)
    );

    initial iClk = 1'b0;
    always #50 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive one bit, let one rising edge pass, and
    // check the MSB-first instance plus the shared strobe on the next falling edge.
    task automatic step(input string tag, input logic b, input av_vec_t exp_vec,
                        input logic exp_valid, input av_vec_t exp_word);
        iSignal = b;
        @(posedge iClk);
        @(negedge iClk);
        check({tag, " vec_m"},   32'(vec_m),   32'(exp_vec));
        check({tag, " valid_m"}, 32'(valid_m), 32'(exp_valid));
        check({tag, " valid_l"}, 32'(valid_l), 32'(exp_valid));
        check({tag, " word_m"},  32'(word_m),  32'(exp_word));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " vec_m"},   32'(vec_m),   32'h0);
        check({tag, " word_m"},  32'(word_m),  32'h0);
        check({tag, " valid_m"}, 32'(valid_m), 32'h0);
        check({tag, " vec_l"},   32'(vec_l),   32'h0);
        check({tag, " word_l"},  32'(word_l),  32'h0);
        check({tag, " valid_l"}, 32'(valid_l), 32'h0);
    endtask

    av_vec_t f1_vec [8] = '{8'h01, 8'h03, 8'h06, 8'h0D, 8'h1B, 8'h37, 8'h6F, 8'h00};
    av_vec_t f2_vec [8] = '{8'hDE, 8'hBC, 8'h79, 8'hF3, 8'hE7, 8'hCF, 8'h9E, 8'h3C};
    logic    f1_bits[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic    f2_bits[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        iRst_n  = 1'b0;
        iSignal = 1'b0;

        // Reset held: iSignal toggles at both clock phases, outputs stay clear.
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            iSignal = ~iSignal;
            @(posedge iClk);
            #10 iSignal = ~iSignal;
            check_all_zero("reset_hold");
        end

        // Frame 1: bits 0,1,1,0,1,1,1,1.
        @(negedge iClk);
        iRst_n = 1'b1;
        step("f1_b1", 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            step("f1", f1_bits[i], f1_vec[i], (i == 6), (i == 6) ? 8'h6F : 8'h00);
        end
        check("f1 word_l", 32'(word_l), 32'hF6);
        check("f1 vec_l",  32'(vec_l),  32'hF6);

        // Frame 2, back-to-back: bits 0,0,1,1,1,1,0,0. oWord holds 0x6F until the pulse.
        for (int i = 0; i < 8; i++) begin
            step("f2", f2_bits[i], f2_vec[i], (i == 7), (i == 7) ? 8'h3C : 8'h6F);
        end

        // Five bits into a new frame, then an asynchronous reset between edges.
        step("mid_b1", 1'b1, 8'h79, 1'b0, 8'h3C);
        step("mid_b2", 1'b0, 8'hF2, 1'b0, 8'h3C);
        step("mid_b3", 1'b1, 8'hE5, 1'b0, 8'h3C);
        step("mid_b4", 1'b0, 8'hCA, 1'b0, 8'h3C);
        step("mid_b5", 1'b1, 8'h95, 1'b0, 8'h3C);
        #10 iRst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge iClk);
        iRst_n = 1'b1;

        // Eight ones after reset: the strobe appears only after the 8th edge.
        step("post_b1", 1'b1, 8'h01, 1'b0, 8'h00);
        step("post_b2", 1'b1, 8'h03, 1'b0, 8'h00);
        step("post_b3", 1'b1, 8'h07, 1'b0, 8'h00);
        step("post_b4", 1'b1, 8'h0F, 1'b0, 8'h00);
        step("post_b5", 1'b1, 8'h1F, 1'b0, 8'h00);
        step("post_b6", 1'b1, 8'h3F, 1'b0, 8'h00);
        step("post_b7", 1'b1, 8'h7F, 1'b0, 8'h00);
        step("post_b8", 1'b1, 8'hFF, 1'b1, 8'hFF);
        check("post word_l", 32'(word_l), 32'hFF);

        // LSB-first frame: bits 1,0,0,0,0,0,0,0 -> dut_l ends at 0x01.
        step("lsb_b1", 1'b1, 8'hFF, 1'b0, 8'hFF);
        check("lsb_b1 vec_l", 32'(vec_l), 32'hFF);
        step("lsb_b2", 1'b0, 8'hFE, 1'b0, 8'hFF);
        check("lsb_b2 vec_l", 32'(vec_l), 32'h7F);
        step("lsb_b3", 1'b0, 8'hFC, 1'b0, 8'hFF);
        step("lsb_b4", 1'b0, 8'hF8, 1'b0, 8'hFF);
        step("lsb_b5", 1'b0, 8'hF0, 1'b0, 8'hFF);
        step("lsb_b6", 1'b0, 8'hE0, 1'b0, 8'hFF);
        step("lsb_b7", 1'b0, 8'hC0, 1'b0, 8'hFF);
        check("lsb_b7 vec_l", 32'(vec_l), 32'h03);
        step("lsb_b8", 1'b0, 8'h80, 1'b1, 8'h80);
        check("lsb vec_l",  32'(vec_l),  32'h01);
        check("lsb word_l", 32'(word_l), 32'h01);

        // 24 zeros: strobe at edges 8, 16 and 24.
        for (int i = 1; i <= 24; i++) begin
            step("zeros", 1'b0, 8'h00, (i % 8 == 0), (i >= 8) ? 8'h00 : 8'h80);
        end
        check("zeros word_l", 32'(word_l), 32'h00);

        // 24 ones: strobe at edges 8, 16 and 24.
        for (int i = 1; i <= 24; i++) begin
            automatic av_vec_t exp_v = (i >= 8) ? 8'hFF : av_vec_t'((1 << i) - 1);
            step("ones", 1'b1, exp_v, (i % 8 == 0), (i >= 8) ? 8'hFF : 8'h00);
        end
        check("ones vec_l",  32'(vec_l),  32'hFF);
        check("ones word_l", 32'(word_l), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_av_serial_vector

// File: doc/av_serial_vector.md
Name: av_serial_vector

Overview:
- Serial-to-parallel accumulator. Samples the 1-bit input `iSignal` on every rising clock edge and shifts it into an 8-bit vector.
- The live vector is always visible on `oVector`.
- A frame strobe and a frame snapshot mark each completed group of WIDTH bits.
- Sits between a serial bit source (sensor or line) and byte-oriented downstream logic.

Parameters:
- WIDTH, 8, vector length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = new bit enters bit 0 and the vector shifts toward the MSB (first bit ends at MSB); 0 = new bit enters bit WIDTH-1 and the vector shifts toward the LSB.

Ports:
- iClk  in  1  clock; all state updates on its rising edge.
- iRst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronous to iClk upstream.
- iSignal  in  1  serial data bit, sampled every rising edge of iClk.
- oVector  out  WIDTH  live shift register contents.
- oValid  out  1  one-cycle strobe: WIDTH new bits have been accumulated since reset or since the previous strobe.
- oWord  out  WIDTH  snapshot of the completed vector; updated only when oValid asserts.

Behaviour:
- Reset (iRst_n=0, any time, independent of clock):
  - shift register, oVector, oWord and bit counter all cleared to 0; oValid=0.
  - Applies mid-frame: partial bits are discarded and the count restarts at 0.
- Each rising edge with iRst_n=1:
  - MSB_FIRST=1: vec <= {vec[WIDTH-2:0], iSignal}.
  - MSB_FIRST=0: vec <= {iSignal, vec[WIDTH-1:1]}.
  - No enable input: a bit is shifted in on every edge.
- Latency: an iSignal value sampled at edge k appears on oVector immediately after edge k (1 cycle, registered output, no combinational path from iSignal).
- Bit counter:
  - Range 0..WIDTH-1, increments on every edge.
  - On the edge that samples the WIDTH-th bit of a frame:
    - counter wraps to 0.
    - oValid=1 for exactly the following cycle.
    - oWord <= the new vector value, i.e. the same value oVector shows in that cycle.
  - oValid=0 in all other cycles.
  - Frames are back-to-back: oValid pulses every WIDTH cycles.
- oVector keeps shifting after a frame completes; oWord holds until the next frame completes.
- Input timing: iSignal must meet setup/hold relative to the iClk rising edge. Changes coincident with the edge are sampled as the pre-edge value.
- No X-propagation handling required beyond reset.

Decomposition:
- Shared package av_pkg:
  - constant AV_WIDTH_DEFAULT=8.
  - typedef av_vec_t (logic [AV_WIDTH_DEFAULT-1:0]).
- One natural sub-module: av_bit_counter.
  - Modulo-WIDTH counter with async active-low reset and a wrap output.
  - The wrap output drives oValid and the oWord load.
- Shift register and snapshot register stay in the top module.

Test Plan:
- Reset check: hold iRst_n=0, toggle iSignal -> oVector=0x00, oWord=0x00, oValid=0 throughout.
- Frame 1 (MSB_FIRST=1, period 100): after reset release, drive bits 0,1,1,0,1,1,1,1 one per edge -> oVector steps 0x00,0x01,0x03,0x06,0x0D,0x1B,0x37,0x6F; after the 8th edge oValid=1 for one cycle and oWord=0x6F.
- Frame 2, continuous: bits 0,0,1,1,1,1,0,0 -> after the 16th edge oVector=0x3C, oValid pulses once, oWord=0x3C; oWord stays 0x6F between the two pulses.
- Mid-frame reset: after 5 bits assert iRst_n=0 asynchronously (between edges) -> outputs clear immediately. Release, then 8 bits of 1 -> oValid only after the 8th post-reset edge, oWord=0xFF.
- MSB_FIRST=0: bits 1,0,0,0,0,0,0,0 -> oVector after 8 edges = 0x01, oWord=0x01.
- All-zero / all-one streams for 24 edges -> oValid pulses exactly at edges 8, 16, 24; oWord=0x00 / 0xFF.
